// File: rtl/wdf_adaptor_2port_if.sv
// Bundle of the adaptor's data-path signals: enable, incident waves, coefficient, reflected waves.
// The master drives the stimulus side and the slave (the adaptor) drives the reflected waves.
interface wdf_adaptor_2port_if #(
  parameter int A1_WID = 10,
  parameter int A2_WID = 12,
  parameter int B1_WID = 13,
  parameter int B2_WID = 12
);
  logic                     en;
  logic signed [A1_WID-1:0] a1;
  logic signed [A2_WID-1:0] a2;
  logic signed [10:0]       alpha;
  logic signed [B1_WID-1:0] b1;
  logic signed [B2_WID-1:0] b2;

  modport master (output en, a1, a2, alpha, input b1, b2);
  modport slave  (input en, a1, a2, alpha, output b1, b2);
endinterface

// File: rtl/wdf_adaptor_2port.sv
// Registered two-port wave-digital adaptor: b = a + alpha*(a2-a1) with per-output saturation.
// MODE selects symmetric/rounded (0), output-swapped/rounded (1) or symmetric/truncated (2).
module wdf_adaptor_2port #(
  parameter int A1_WID = 10,
  parameter int A2_WID = 12,
  parameter int B1_WID = 13,
  parameter int B2_WID = 12,
  parameter int MODE   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wdf_adaptor_2port_if.slave   bus
);
  localparam int W    = ((A1_WID > A2_WID) ? A1_WID : A2_WID) + 1;
  localparam int PW   = W + 11;
  localparam int SW   = W + 2;
  localparam int CW_T = (SW > B1_WID) ? SW : B1_WID;
  localparam int CW   = ((CW_T > B2_WID) ? CW_T : B2_WID) + 1;

  // Unsupported MODE values fall back to the symmetric/rounded flavour.
  localparam bit SWAP  = (MODE == 1);
  localparam bit TRUNC = (MODE == 2);

  localparam logic signed [PW-1:0] RND    = TRUNC ? PW'(0) : PW'(512);
  localparam logic signed [CW-1:0] B1_MAX = CW'((64'sd1 <<< (B1_WID - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] B1_MIN = CW'(-(64'sd1 <<< (B1_WID - 1)));
  localparam logic signed [CW-1:0] B2_MAX = CW'((64'sd1 <<< (B2_WID - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] B2_MIN = CW'(-(64'sd1 <<< (B2_WID - 1)));

  logic signed [W-1:0]      a1_x, a2_x, d;
  logic signed [10:0]       alpha_s;
  logic signed [PW-1:0]     prod, prod_r;
  logic signed [SW-1:0]     p, s1, s2;
  logic signed [CW-1:0]     s1_c, s2_c;
  logic signed [B1_WID-1:0] b1_sat, b1_d, b1_q;
  logic signed [B2_WID-1:0] b2_sat, b2_d, b2_q;

  always_comb begin
    a1_x    = {{(W - A1_WID){bus.a1[A1_WID-1]}}, bus.a1};
    a2_x    = {{(W - A2_WID){bus.a2[A2_WID-1]}}, bus.a2};
    alpha_s = bus.alpha;
    d       = a2_x - a1_x;
    prod    = PW'(d) * PW'(alpha_s);
    prod_r  = prod + RND;
    p       = SW'(prod_r >>> 10);

    if (SWAP) begin
      s1 = SW'(a1_x) + p;
      s2 = SW'(a2_x) + p;
    end else begin
      s1 = SW'(a2_x) + p;
      s2 = SW'(a1_x) + p;
    end

    // Widen to a common compare width so the clamp limits are always representable.
    s1_c = CW'(s1);
    s2_c = CW'(s2);

    if (s1_c > B1_MAX)      b1_sat = B1_MAX[B1_WID-1:0];
    else if (s1_c < B1_MIN) b1_sat = B1_MIN[B1_WID-1:0];
    else                    b1_sat = s1_c[B1_WID-1:0];

    if (s2_c > B2_MAX)      b2_sat = B2_MAX[B2_WID-1:0];
    else if (s2_c < B2_MIN) b2_sat = B2_MIN[B2_WID-1:0];
    else                    b2_sat = s2_c[B2_WID-1:0];

    b1_d = bus.en ? b1_sat : b1_q;
    b2_d = bus.en ? b2_sat : b2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      b1_q <= b1_d;
      b2_q <= b2_d;
    end
  end

  assign bus.b1 = b1_q;
  assign bus.b2 = b2_q;
endmodule

// File: tb/tb_wdf_adaptor_2port.sv
// Bench for wdf_adaptor_2port: one instance per MODE driven in parallel with directed vectors,
// then a random stream checked against an integer reference model, with a mid-stream reset.
module tb_wdf_adaptor_2port;
  logic clk;
  logic reset_n;

  int n_checks = 0;
  int n_fail   = 0;

  wdf_adaptor_2port_if if0 ();
  wdf_adaptor_2port_if if1 ();
  wdf_adaptor_2port_if if2 ();

  wdf_adaptor_2port #(.MODE(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  wdf_adaptor_2port #(.MODE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  wdf_adaptor_2port #(.MODE(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint obs_b1(input int m);
    if (m == 0) return longint'(if0.b1);
    if (m == 1) return longint'(if1.b1);
    return longint'(if2.b1);
  endfunction

  function automatic longint obs_b2(input int m);
    if (m == 0) return longint'(if0.b2);
    if (m == 1) return longint'(if1.b2);
    return longint'(if2.b2);
  endfunction

  task automatic set_in(input int a1, input int a2, input int al, input logic en);
    if0.a1 = 10'(a1); if0.a2 = 12'(a2); if0.alpha = 11'(al); if0.en = en;
    if1.a1 = 10'(a1); if1.a2 = 12'(a2); if1.alpha = 11'(al); if1.en = en;
    if2.a1 = 10'(a1); if2.a2 = 12'(a2); if2.alpha = 11'(al); if2.en = en;
  endtask

  // Reference: floor division by 1024 done with plain integer arithmetic.
  function automatic void model(input int m, input int a1, input int a2, input int al,
                                output int b1, output int b2);
    longint prod, p, s1, s2;
    prod = longint'(a2 - a1) * longint'(al);
    if (m != 2) prod = prod + 512;
    p = prod / 1024;
    if ((prod % 1024 != 0) && (prod < 0)) p = p - 1;
    if (m == 1) begin s1 = a1 + p; s2 = a2 + p; end
    else        begin s1 = a2 + p; s2 = a1 + p; end
    if (s1 > 4095) s1 = 4095; else if (s1 < -4096) s1 = -4096;
    if (s2 > 2047) s2 = 2047; else if (s2 < -2048) s2 = -2048;
    b1 = int'(s1);
    b2 = int'(s2);
  endfunction

  // One directed vector: apply with en=1, one edge, compare all three flavours.
  task automatic vec(input string name, input int a1, input int a2, input int al,
                     input int m0b1, input int m0b2, input int m1b1, input int m1b2,
                     input int m2b1, input int m2b2);
    set_in(a1, a2, al, 1'b1);
    @(posedge clk); #1;
    $display("vec %s a1=%0d a2=%0d alpha=%0d -> m0 %0d/%0d m1 %0d/%0d m2 %0d/%0d",
             name, a1, a2, al, if0.b1, if0.b2, if1.b1, if1.b2, if2.b1, if2.b2);
    check_val({name, " m0 b1"}, obs_b1(0), m0b1);
    check_val({name, " m0 b2"}, obs_b2(0), m0b2);
    check_val({name, " m1 b1"}, obs_b1(1), m1b1);
    check_val({name, " m1 b2"}, obs_b2(1), m1b2);
    check_val({name, " m2 b1"}, obs_b1(2), m2b1);
    check_val({name, " m2 b2"}, obs_b2(2), m2b2);
  endtask

  int exp_b1 [3];
  int exp_b2 [3];

  initial begin
    reset_n = 1'b0;
    set_in(123, -456, 300, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      check_val($sformatf("reset m%0d b1", m), obs_b1(m), 0);
      check_val($sformatf("reset m%0d b2", m), obs_b2(m), 0);
    end
    $display("reset held: outputs m0 %0d/%0d", if0.b1, if0.b2);
    reset_n = 1'b1;

    vec("first",    5,    7,     0,     7,    5,     5,    7,     7,    5);
    vec("a662",     100,  0,     662,   -65,  35,    35,   -65,   -65,  35);
    vec("an795",    0,    200,   -795,  45,   -155,  -155, 45,    44,   -156);
    vec("round",    -100, 0,     662,   65,   -35,   -35,  65,    64,   -36);
    vec("satpos",   -512, 2047,  1023,  4095, 2045,  2045, 2047,  4095, 2044);
    vec("satneg",   511,  -2048, 1023,  -4096,-2046, -2046,-2048, -4096,-2046);
    vec("am1024",   -512, -2048, -1024, -512, 1024,  1024, -512,  -512, 1024);
    vec("am1024b",  511,  -2048, -1024, 511,  2047,  3070, 511,   511,  2047);
    vec("alpha0",   -300, 1000,  0,     1000, -300,  -300, 1000,  1000, -300);

    // Enable/hold: load, then scramble inputs with en low.
    vec("load",     100,  0,     662,   -65,  35,    35,   -65,   -65,  35);
    for (int k = 0; k < 3; k++) begin
      set_in(-7 * k - 1, 333 + k, -1024 + k, 1'b0);
      @(posedge clk); #1;
      $display("hold cycle %0d: m0 b1=%0d b2=%0d", k, if0.b1, if0.b2);
      check_val($sformatf("hold%0d m0 b1", k), obs_b1(0), -65);
      check_val($sformatf("hold%0d m0 b2", k), obs_b2(0), 35);
      check_val($sformatf("hold%0d m1 b1", k), obs_b1(1), 35);
    end
    vec("resume",   0,    200,   -795,  45,   -155,  -155, 45,    44,   -156);

    for (int m = 0; m < 3; m++) begin
      exp_b1[m] = int'(obs_b1(m) == 0 ? 0 : 0);
      exp_b2[m] = 0;
    end
    // Re-establish known state for the random stream from the last directed vector.
    exp_b1[0] = 45;   exp_b2[0] = -155;
    exp_b1[1] = -155; exp_b2[1] = 45;
    exp_b1[2] = 44;   exp_b2[2] = -156;

    for (int i = 0; i < 1000; i++) begin
      int ra1, ra2, ral;
      logic ren;
      ra1 = int'($urandom_range(0, 1023)) - 512;
      ra2 = int'($urandom_range(0, 4095)) - 2048;
      ral = int'($urandom_range(0, 2047)) - 1024;
      ren = ($urandom_range(0, 3) != 0);
      set_in(ra1, ra2, ral, ren);
      @(posedge clk); #1;
      if (ren) begin
        for (int m = 0; m < 3; m++) model(m, ra1, ra2, ral, exp_b1[m], exp_b2[m]);
      end
      if (i % 100 == 0)
        $display("rand %0d a1=%0d a2=%0d alpha=%0d en=%0b m0 %0d/%0d", i, ra1, ra2, ral, ren,
                 if0.b1, if0.b2);
      for (int m = 0; m < 3; m++) begin
        check_val($sformatf("rand%0d m%0d b1", i, m), obs_b1(m), exp_b1[m]);
        check_val($sformatf("rand%0d m%0d b2", i, m), obs_b2(m), exp_b2[m]);
      end
      if (i == 500) begin
        reset_n = 1'b0;
        #1;
        $display("mid-stream reset: m0 %0d/%0d", if0.b1, if0.b2);
        for (int m = 0; m < 3; m++) begin
          check_val($sformatf("midrst m%0d b1", m), obs_b1(m), 0);
          check_val($sformatf("midrst m%0d b2", m), obs_b2(m), 0);
          exp_b1[m] = 0;
          exp_b2[m] = 0;
        end
        #1;
        reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
